// File: rtl/writeback_retire.sv
// -----------------------------------------------------------------------------
// writeback_retire
//
// Registered writeback / retire stage that sits after the memory stage.
//   * Selects and sign/zero-extends the load lane for LB/LBU/LH/LHU/LW.
//   * Runs a stalling CSR read handshake. A timeout turns into a trap that
//     redirects the PC to TRAP_VECTOR.
//   * Commits at most one instruction per cycle to the register file.
//   * Keeps an instruction-retired counter.
// Commit outputs are registered: an instruction accepted at a clock edge is
// visible on the writeback_* / retire_* outputs for the cycle that follows.
//
// Handshake: an instruction is accepted in any IDLE cycle where clk_en=1.
// While next_stall=1 (CSR_WAIT), upstream holds its instruction and this
// block ignores clk_en. A CSR read completes on the first CSR_WAIT cycle
// with csr_rd_ack=1; csr_data is sampled in that same cycle.
//
// FSM state is observable on csr_rd_req / next_stall. Both are high exactly
// when the FSM is in CSR_WAIT, and the FSM has only IDLE and CSR_WAIT.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   clk_en                instruction valid from the memory stage
//   memory_*              instruction fields from the memory stage
//   csr_rd_req            CSR read request (high in CSR_WAIT)
//   csr_rd_ack, csr_data  CSR read response
//   writeback_*           register-file write port and committed/redirect PC
//   retire_valid          one instruction retired this cycle
//   retire_count          retired-instruction count (wraps)
//   csr_error             sticky CSR timeout flag
//   next_stall            stall upstream
//   next_flush            flush upstream (on trap)
// -----------------------------------------------------------------------------
module writeback_retire #(
  parameter int          CNT_W        = 64,
  parameter int          CSR_TIMEOUT  = 16,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0004,
  parameter int          OPCODE_WIDTH = 11,
  parameter int          OP_LOAD      = 3,
  parameter int          OP_SYSTEM    = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clk_en,
  input  logic [2:0]              memory_funct3,
  input  logic [1:0]              memory_addr_lsb,
  input  logic [31:0]             memory_data_load,
  input  logic [OPCODE_WIDTH-1:0] memory_opcode_type,
  input  logic                    memory_rd_wr_en,
  input  logic [4:0]              memory_rd,
  input  logic [31:0]             memory_rd_wr_data,
  input  logic [31:0]             memory_pc,
  output logic                    csr_rd_req,
  input  logic                    csr_rd_ack,
  input  logic [31:0]             csr_data,
  output logic                    writeback_rd_wr_en,
  output logic [4:0]              writeback_rd,
  output logic [31:0]             writeback_rd_wr_data,
  output logic [31:0]             writeback_pc,
  output logic                    writeback_change_pc,
  output logic                    retire_valid,
  output logic [CNT_W-1:0]        retire_count,
  output logic                    csr_error,
  output logic                    next_stall,
  output logic                    next_flush
);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    CSR_WAIT = 1'b1
  } state_t;

  // The timer value in the last CSR_WAIT cycle before a trap. The trap fires
  // at the end of the CSR_TIMEOUT-th wait cycle when no ack arrives.
  localparam logic [7:0] TIMEOUT_LAST = 8'(CSR_TIMEOUT - 1);

  state_t      state, state_next;
  logic [7:0]  timer, timer_next;

  // Instruction fields held across the CSR wait
  logic        cap_rd_wr_en;
  logic [4:0]  cap_rd;
  logic [31:0] cap_pc;

  // Combinational decode of the current cycle
  logic        accept;
  logic        is_load;
  logic        is_csr;
  logic        capture;
  logic        commit;
  logic        trap;
  logic        commit_wr_en;
  logic [4:0]  commit_rd;
  logic [31:0] commit_pc;
  logic [31:0] commit_data;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_ext;

  // Only the LOAD and SYSTEM bits of the one-hot opcode are decoded here
  logic        unused_opcode_bits;
  assign unused_opcode_bits = ^memory_opcode_type;

  assign csr_rd_req = (state == CSR_WAIT);
  assign next_stall = (state == CSR_WAIT);

  // ---------------------------------------------------------------------------
  // Load lane selection and extension
  // ---------------------------------------------------------------------------
  always_comb begin
    load_byte = 8'h00;
    load_half = 16'h0000;
    load_ext  = memory_data_load;

    case (memory_addr_lsb)
      2'd0:    load_byte = memory_data_load[7:0];
      2'd1:    load_byte = memory_data_load[15:8];
      2'd2:    load_byte = memory_data_load[23:16];
      default: load_byte = memory_data_load[31:24];
    endcase

    // Halfword lane uses only addr_lsb[1]; a misaligned bit 0 is ignored
    load_half = memory_addr_lsb[1] ? memory_data_load[31:16]
                                   : memory_data_load[15:0];

    case (memory_funct3)
      3'b000:  load_ext = {{24{load_byte[7]}}, load_byte};
      3'b100:  load_ext = {24'h000000, load_byte};
      3'b001:  load_ext = {{16{load_half[15]}}, load_half};
      3'b101:  load_ext = {16'h0000, load_half};
      default: load_ext = memory_data_load; // LW and undefined widths
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state, commit and trap decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next   = state;
    timer_next   = timer;
    accept       = 1'b0;
    is_load      = memory_opcode_type[OP_LOAD];
    is_csr       = 1'b0;
    capture      = 1'b0;
    commit       = 1'b0;
    trap         = 1'b0;
    commit_wr_en = memory_rd_wr_en;
    commit_rd    = memory_rd;
    commit_pc    = memory_pc;
    commit_data  = memory_rd_wr_data;

    // LOAD wins over SYSTEM if both bits were ever set
    is_csr = !is_load && memory_opcode_type[OP_SYSTEM] &&
             (memory_funct3 != 3'b000);

    case (state)
      IDLE: begin
        accept = clk_en;
        if (accept) begin
          if (is_csr) begin
            capture    = 1'b1;
            state_next = CSR_WAIT;
            timer_next = 8'd0;
          end else begin
            commit      = 1'b1;
            commit_data = is_load ? load_ext : memory_rd_wr_data;
          end
        end
      end

      CSR_WAIT: begin
        commit_wr_en = cap_rd_wr_en;
        commit_rd    = cap_rd;
        commit_pc    = cap_pc;
        commit_data  = csr_data;
        timer_next   = timer + 8'd1;
        // An ack in the same cycle as the timeout wins over the trap
        if (csr_rd_ack) begin
          commit     = 1'b1;
          state_next = IDLE;
        end else if (timer == TIMEOUT_LAST) begin
          trap       = 1'b1;
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, captured fields and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= IDLE;
      timer                <= 8'd0;
      cap_rd_wr_en         <= 1'b0;
      cap_rd               <= 5'd0;
      cap_pc               <= 32'd0;
      writeback_rd_wr_en   <= 1'b0;
      writeback_rd         <= 5'd0;
      writeback_rd_wr_data <= 32'd0;
      writeback_pc         <= 32'd0;
      writeback_change_pc  <= 1'b0;
      retire_valid         <= 1'b0;
      retire_count         <= '0;
      csr_error            <= 1'b0;
      next_flush           <= 1'b0;
    end else begin
      state <= state_next;
      timer <= timer_next;

      if (capture) begin
        cap_rd_wr_en <= memory_rd_wr_en;
        cap_rd       <= memory_rd;
        cap_pc       <= memory_pc;
      end

      // Enables are single-cycle pulses; x0 writes are suppressed
      writeback_rd_wr_en  <= commit && commit_wr_en && (commit_rd != 5'd0);
      retire_valid        <= commit;
      writeback_change_pc <= trap;
      next_flush          <= trap;

      // Data path holds its last value when nothing commits
      if (commit) begin
        writeback_rd         <= commit_rd;
        writeback_rd_wr_data <= commit_data;
        writeback_pc         <= commit_pc;
        retire_count         <= retire_count + CNT_W'(1);
      end else if (trap) begin
        writeback_pc <= TRAP_VECTOR;
      end

      if (trap) begin
        csr_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_writeback_retire.sv
// -----------------------------------------------------------------------------
// tb_writeback_retire
//
// Directed bench for writeback_retire. It uses CNT_W=4 so the retire counter
// wraps quickly, and CSR_TIMEOUT=4 so a trap happens after four wait cycles.
// Expected values are hand-computed constants, plus a small retire-count
// model and an expected-data queue for back-to-back commits.
// -----------------------------------------------------------------------------
module tb_writeback_retire;

  localparam int OPW       = 11;
  localparam int OP_LOAD   = 3;
  localparam int OP_SYSTEM = 10;
  localparam int OP_ALU    = 4;
  localparam int CNT_W     = 4;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             clk_en;
  logic [2:0]       memory_funct3;
  logic [1:0]       memory_addr_lsb;
  logic [31:0]      memory_data_load;
  logic [OPW-1:0]   memory_opcode_type;
  logic             memory_rd_wr_en;
  logic [4:0]       memory_rd;
  logic [31:0]      memory_rd_wr_data;
  logic [31:0]      memory_pc;
  logic             csr_rd_req;
  logic             csr_rd_ack;
  logic [31:0]      csr_data;
  logic             writeback_rd_wr_en;
  logic [4:0]       writeback_rd;
  logic [31:0]      writeback_rd_wr_data;
  logic [31:0]      writeback_pc;
  logic             writeback_change_pc;
  logic             retire_valid;
  logic [CNT_W-1:0] retire_count;
  logic             csr_error;
  logic             next_stall;
  logic             next_flush;

  writeback_retire #(
    .CNT_W        (CNT_W),
    .CSR_TIMEOUT  (4),
    .TRAP_VECTOR  (32'h0000_0004),
    .OPCODE_WIDTH (OPW),
    .OP_LOAD      (OP_LOAD),
    .OP_SYSTEM    (OP_SYSTEM)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .clk_en               (clk_en),
    .memory_funct3        (memory_funct3),
    .memory_addr_lsb      (memory_addr_lsb),
    .memory_data_load     (memory_data_load),
    .memory_opcode_type   (memory_opcode_type),
    .memory_rd_wr_en      (memory_rd_wr_en),
    .memory_rd            (memory_rd),
    .memory_rd_wr_data    (memory_rd_wr_data),
    .memory_pc            (memory_pc),
    .csr_rd_req           (csr_rd_req),
    .csr_rd_ack           (csr_rd_ack),
    .csr_data             (csr_data),
    .writeback_rd_wr_en   (writeback_rd_wr_en),
    .writeback_rd         (writeback_rd),
    .writeback_rd_wr_data (writeback_rd_wr_data),
    .writeback_pc         (writeback_pc),
    .writeback_change_pc  (writeback_change_pc),
    .retire_valid         (retire_valid),
    .retire_count         (retire_count),
    .csr_error            (csr_error),
    .next_stall           (next_stall),
    .next_flush           (next_flush)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int               n_checks = 0;
  int               n_pass   = 0;
  logic [CNT_W-1:0] exp_cnt  = '0;
  logic [31:0]      exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Advance one clock; outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    clk_en             = 1'b0;
    memory_funct3      = 3'b000;
    memory_addr_lsb    = 2'd0;
    memory_data_load   = 32'd0;
    memory_opcode_type = '0;
    memory_rd_wr_en    = 1'b0;
    memory_rd          = 5'd0;
    memory_rd_wr_data  = 32'd0;
    memory_pc          = 32'd0;
  endtask

  task automatic drive_load(input logic [2:0] f3, input logic [1:0] lsb,
                            input logic [31:0] word, input logic [4:0] rd);
    drive_idle();
    clk_en                      = 1'b1;
    memory_opcode_type[OP_LOAD] = 1'b1;
    memory_funct3               = f3;
    memory_addr_lsb             = lsb;
    memory_data_load            = word;
    memory_rd_wr_en             = 1'b1;
    memory_rd                   = rd;
    memory_rd_wr_data           = 32'hAAAA_AAAA; // must not be selected
    memory_pc                   = 32'h0000_0040;
  endtask

  task automatic drive_alu(input logic [4:0] rd, input logic [31:0] data,
                           input logic [31:0] pc);
    drive_idle();
    clk_en                     = 1'b1;
    memory_opcode_type[OP_ALU] = 1'b1;
    memory_rd_wr_en            = 1'b1;
    memory_rd                  = rd;
    memory_rd_wr_data          = data;
    memory_pc                  = pc;
  endtask

  task automatic drive_csr(input logic [4:0] rd, input logic [31:0] pc);
    drive_idle();
    clk_en                        = 1'b1;
    memory_opcode_type[OP_SYSTEM] = 1'b1;
    memory_funct3                 = 3'b010;
    memory_rd_wr_en               = 1'b1;
    memory_rd                     = rd;
    memory_pc                     = pc;
  endtask

  // Reset-state values of every registered output
  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_en"},  64'(writeback_rd_wr_en),   64'd0);
    check({tag, "_retire"}, 64'(retire_valid),         64'd0);
    check({tag, "_count"},  64'(retire_count),         64'd0);
    check({tag, "_err"},    64'(csr_error),            64'd0);
    check({tag, "_req"},    64'(csr_rd_req),           64'd0);
    check({tag, "_stall"},  64'(next_stall),           64'd0);
    check({tag, "_flush"},  64'(next_flush),           64'd0);
    check({tag, "_chpc"},   64'(writeback_change_pc),  64'd0);
    check({tag, "_rd"},     64'(writeback_rd),         64'd0);
    check({tag, "_data"},   64'(writeback_rd_wr_data), 64'd0);
    check({tag, "_pc"},     64'(writeback_pc),         64'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    drive_idle();
    csr_rd_ack = 1'b0;
    csr_data   = 32'd0;
    rst        = 1'b1;
    tick();
    tick();
    check_reset_outputs("rst");
    rst = 1'b0;

    // LB / LBU: byte lane 2 of 0x12803456 is 0x80
    drive_load(3'b000, 2'd2, 32'h1280_3456, 5'd3);
    tick();
    exp_cnt++;
    check("lb_data",   64'(writeback_rd_wr_data), 64'hFFFF_FF80);
    check("lb_wr_en",  64'(writeback_rd_wr_en),   64'd1);
    check("lb_retire", 64'(retire_valid),         64'd1);
    check("lb_rd",     64'(writeback_rd),         64'd3);
    check("lb_pc",     64'(writeback_pc),         64'h40);
    drive_load(3'b100, 2'd2, 32'h1280_3456, 5'd3);
    tick();
    exp_cnt++;
    check("lbu_data", 64'(writeback_rd_wr_data), 64'h0000_0080);

    // LH / LHU / LW: addr_lsb=3 selects the upper halfword 0x8001
    drive_load(3'b001, 2'd3, 32'h8001_7FFF, 5'd4);
    tick();
    exp_cnt++;
    check("lh_data", 64'(writeback_rd_wr_data), 64'hFFFF_8001);
    drive_load(3'b101, 2'd3, 32'h8001_7FFF, 5'd4);
    tick();
    exp_cnt++;
    check("lhu_data", 64'(writeback_rd_wr_data), 64'h0000_8001);
    drive_load(3'b010, 2'd3, 32'h8001_7FFF, 5'd4);
    tick();
    exp_cnt++;
    check("lw_data",  64'(writeback_rd_wr_data), 64'h8001_7FFF);
    check("lw_count", 64'(retire_count),         64'(exp_cnt));

    // Idle cycle: enables drop, data holds
    drive_idle();
    tick();
    check("idle_wr_en",  64'(writeback_rd_wr_en),   64'd0);
    check("idle_retire", 64'(retire_valid),         64'd0);
    check("idle_data",   64'(writeback_rd_wr_data), 64'h8001_7FFF);

    // CSR read acked in the third wait cycle
    drive_csr(5'd5, 32'h0000_0100);
    tick();
    check("csr_req_w1",   64'(csr_rd_req),   64'd1);
    check("csr_stall_w1", 64'(next_stall),   64'd1);
    check("csr_ret_w1",   64'(retire_valid), 64'd0);
    tick();
    check("csr_stall_w2", 64'(next_stall), 64'd1);
    tick();
    check("csr_stall_w3", 64'(next_stall), 64'd1);
    csr_rd_ack = 1'b1;
    csr_data   = 32'hDEAD_BEEF;
    clk_en     = 1'b0;
    tick();
    csr_rd_ack = 1'b0;
    csr_data   = 32'd0;
    exp_cnt++;
    check("csr_stall_done", 64'(next_stall),           64'd0);
    check("csr_rd",         64'(writeback_rd),         64'd5);
    check("csr_data",       64'(writeback_rd_wr_data), 64'hDEAD_BEEF);
    check("csr_wr_en",      64'(writeback_rd_wr_en),   64'd1);
    check("csr_retire",     64'(retire_valid),         64'd1);
    check("csr_pc",         64'(writeback_pc),         64'h100);
    check("csr_count",      64'(retire_count),         64'(exp_cnt));

    // CSR timeout: four wait cycles, then a trap
    drive_csr(5'd6, 32'h0000_0200);
    tick();
    clk_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("to_stall_w%0d", i + 1), 64'(next_stall), 64'd1);
      tick();
    end
    check("trap_chpc",   64'(writeback_change_pc), 64'd1);
    check("trap_pc",     64'(writeback_pc),        64'h4);
    check("trap_flush",  64'(next_flush),          64'd1);
    check("trap_wr_en",  64'(writeback_rd_wr_en),  64'd0);
    check("trap_retire", 64'(retire_valid),        64'd0);
    check("trap_err",    64'(csr_error),           64'd1);
    check("trap_stall",  64'(next_stall),          64'd0);
    check("trap_count",  64'(retire_count),        64'(exp_cnt));
    tick();
    check("post_trap_chpc",  64'(writeback_change_pc), 64'd0);
    check("post_trap_flush", 64'(next_flush),          64'd0);
    check("post_trap_err",   64'(csr_error),           64'd1);

    // ALU write to x0 is suppressed but still retires
    drive_alu(5'd0, 32'h0000_0055, 32'h0000_0300);
    tick();
    exp_cnt++;
    check("x0_wr_en",  64'(writeback_rd_wr_en), 64'd0);
    check("x0_retire", 64'(retire_valid),       64'd1);

    // Three back-to-back ALU ops commit on consecutive cycles
    for (int i = 1; i <= 3; i++) begin
      drive_alu(5'(i), 32'(i * 32'h11), 32'(32'h400 + i * 4));
      exp_q.push_back(32'(i * 32'h11));
      tick();
      exp_cnt++;
      check($sformatf("b2b_retire%0d", i), 64'(retire_valid),         64'd1);
      check($sformatf("b2b_data%0d", i),   64'(writeback_rd_wr_data), 64'(exp_q.pop_front()));
      check($sformatf("b2b_rd%0d", i),     64'(writeback_rd),         64'(i));
    end
    check("b2b_count", 64'(retire_count), 64'(exp_cnt));
    drive_idle();
    tick();

    // Counter wrap: 17 retirements from reset leave the 4-bit count at 1
    rst = 1'b1;
    tick();
    rst     = 1'b0;
    exp_cnt = '0;
    check("rst_clears_err", 64'(csr_error), 64'd0);
    for (int i = 1; i <= 17; i++) begin
      drive_alu(5'd7, 32'(i), 32'h0000_0500);
      tick();
      exp_cnt++;
      if (i >= 15) check($sformatf("wrap_count%0d", i), 64'(retire_count), 64'(exp_cnt));
    end
    check("wrap_final", 64'(retire_count), 64'd1);

    // Reset during CSR_WAIT abandons the instruction
    drive_csr(5'd9, 32'h0000_0600);
    tick();
    check("midrst_req_before", 64'(csr_rd_req), 64'd1);
    drive_idle();
    rst = 1'b1;
    tick();
    check_reset_outputs("midrst");
    rst = 1'b0;
    tick();
    check("midrst_no_commit", 64'(retire_valid), 64'd0);
    check("midrst_no_trap",   64'(writeback_change_pc), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
